// File: rtl/tdc_seq_pkg.sv
// Shared constants and state type for the TDC encoder sequencer.
package tdc_seq_pkg;

  localparam int RAW_W  = 63;
  localparam int CNT_W  = 3;
  localparam int CODE_W = 10;
  localparam int DROP_W = 8;

  localparam int TOA_IDX = 0;
  localparam int TOT_IDX = 1;
  localparam int CAL_IDX = 2;

  typedef enum logic [2:0] {
    IDLE,
    ENC_TOA,
    ENC_TOT,
    ENC_CAL,
    OUT
  } seq_state_e;

endpackage

// File: rtl/tdc_raw_latch.sv
// Holds the three latched raw/counter sets of a hit and muxes the selected set
// onto the shared encoder inputs; no selection drives zeros.
module tdc_raw_latch
  import tdc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [2:0]       sel_i,
  input  logic [RAW_W-1:0] toa_raw_i,
  input  logic [RAW_W-1:0] tot_raw_i,
  input  logic [RAW_W-1:0] cal_raw_i,
  input  logic [CNT_W-1:0] toa_cnta_i,
  input  logic [CNT_W-1:0] toa_cntb_i,
  input  logic [CNT_W-1:0] tot_cnta_i,
  input  logic [CNT_W-1:0] tot_cntb_i,
  input  logic [CNT_W-1:0] cal_cnta_i,
  input  logic [CNT_W-1:0] cal_cntb_i,
  output logic [RAW_W-1:0] enc_a_o,
  output logic [CNT_W-1:0] enc_cnta_o,
  output logic [CNT_W-1:0] enc_cntb_o
);

  logic [RAW_W-1:0] raw_q  [3];
  logic [CNT_W-1:0] cnta_q [3];
  logic [CNT_W-1:0] cntb_q [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        raw_q[i]  <= '0;
        cnta_q[i] <= '0;
        cntb_q[i] <= '0;
      end
    end else if (load_i) begin
      raw_q[TOA_IDX]  <= toa_raw_i;
      raw_q[TOT_IDX]  <= tot_raw_i;
      raw_q[CAL_IDX]  <= cal_raw_i;
      cnta_q[TOA_IDX] <= toa_cnta_i;
      cnta_q[TOT_IDX] <= tot_cnta_i;
      cnta_q[CAL_IDX] <= cal_cnta_i;
      cntb_q[TOA_IDX] <= toa_cntb_i;
      cntb_q[TOT_IDX] <= tot_cntb_i;
      cntb_q[CAL_IDX] <= cal_cntb_i;
    end
  end

  // sel_i is one-hot or zero, so OR-ing the gated sets is a plain mux
  always_comb begin
    enc_a_o    = '0;
    enc_cnta_o = '0;
    enc_cntb_o = '0;
    for (int i = 0; i < 3; i++) begin
      if (sel_i[i]) begin
        enc_a_o    = enc_a_o    | raw_q[i];
        enc_cnta_o = enc_cnta_o | cnta_q[i];
        enc_cntb_o = enc_cntb_o | cntb_q[i];
      end
    end
  end

endmodule

// File: rtl/tdc_enc_sequencer.sv
// Shares one TDC phase encoder across the TOA/TOT/CAL captures of a hit.
// States: IDLE wait hit | ENC_x drive set x, capture code | OUT hold result. Macro TDC_SEQ_SETTLE_EN: 2 cycles per ENC_x.
module tdc_enc_sequencer
  import tdc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic [RAW_W-1:0]  toa_raw,
  input  logic [RAW_W-1:0]  tot_raw,
  input  logic [RAW_W-1:0]  cal_raw,
  input  logic [CNT_W-1:0]  toa_cntA,
  input  logic [CNT_W-1:0]  toa_cntB,
  input  logic [CNT_W-1:0]  tot_cntA,
  input  logic [CNT_W-1:0]  tot_cntB,
  input  logic [CNT_W-1:0]  cal_cntA,
  input  logic [CNT_W-1:0]  cal_cntB,
  input  logic              cal_en,
  output logic [RAW_W-1:0]  enc_A,
  output logic [CNT_W-1:0]  enc_cntA,
  output logic [CNT_W-1:0]  enc_cntB,
  input  logic [CODE_W-1:0] enc_code,
  input  logic              enc_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_toa,
  output logic [CODE_W-1:0] out_tot,
  output logic [CODE_W-1:0] out_cal,
  output logic [2:0]        out_err,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  seq_state_e        state_q, state_d;
  logic              cal_en_q;
  logic              accept;
  logic              step;
  logic [2:0]        sel;
  logic [CODE_W-1:0] out_toa_q, out_tot_q, out_cal_q;
  logic [2:0]        out_err_q;
  logic [DROP_W-1:0] drop_q;
`ifdef TDC_SEQ_SETTLE_EN
  logic              phase_q, phase_d;
`endif

  assign accept        = (state_q == IDLE) && hit;
  assign sel[TOA_IDX]  = (state_q == ENC_TOA);
  assign sel[TOT_IDX]  = (state_q == ENC_TOT);
  assign sel[CAL_IDX]  = (state_q == ENC_CAL);

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
`ifdef TDC_SEQ_SETTLE_EN
    phase_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (hit) state_d = ENC_TOA;
      ENC_TOA, ENC_TOT, ENC_CAL: begin
`ifdef TDC_SEQ_SETTLE_EN
        // phase 0 lets the encoder settle, phase 1 captures and advances
        phase_d = ~phase_q;
        step    = phase_q;
`else
        step    = 1'b1;
`endif
        if (step) begin
          case (state_q)
            ENC_TOA: state_d = ENC_TOT;
            ENC_TOT: state_d = cal_en_q ? ENC_CAL : OUT;
            default: state_d = OUT;
          endcase
        end
      end
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cal_en_q  <= 1'b0;
      out_toa_q <= '0;
      out_tot_q <= '0;
      out_cal_q <= '0;
      out_err_q <= '0;
      drop_q    <= '0;
`ifdef TDC_SEQ_SETTLE_EN
      phase_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef TDC_SEQ_SETTLE_EN
      phase_q <= phase_d;
`endif
      if (accept) begin
        cal_en_q  <= cal_en;
        out_toa_q <= '0;
        out_tot_q <= '0;
        out_cal_q <= '0;
        out_err_q <= '0;
      end else if (step) begin
        if (sel[TOA_IDX]) begin
          out_toa_q          <= enc_code;
          out_err_q[TOA_IDX] <= enc_err;
        end
        if (sel[TOT_IDX]) begin
          out_tot_q          <= enc_code;
          out_err_q[TOT_IDX] <= enc_err;
        end
        if (sel[CAL_IDX]) begin
          out_cal_q          <= enc_code;
          out_err_q[CAL_IDX] <= enc_err;
        end
      end
      if (hit && (state_q != IDLE) && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  tdc_raw_latch u_latch (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .sel_i      (sel),
    .toa_raw_i  (toa_raw),
    .tot_raw_i  (tot_raw),
    .cal_raw_i  (cal_raw),
    .toa_cnta_i (toa_cntA),
    .toa_cntb_i (toa_cntB),
    .tot_cnta_i (tot_cntA),
    .tot_cntb_i (tot_cntB),
    .cal_cnta_i (cal_cntA),
    .cal_cntb_i (cal_cntB),
    .enc_a_o    (enc_A),
    .enc_cnta_o (enc_cntA),
    .enc_cntb_o (enc_cntB)
  );

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign out_toa   = out_toa_q;
  assign out_tot   = out_tot_q;
  assign out_cal   = out_cal_q;
  assign out_err   = out_err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tdc_enc_sequencer.sv
// Randomized bench for tdc_enc_sequencer with a transaction-level model and
// a few hand-computed directed expectations.
module tb_tdc_enc_sequencer;
  import tdc_seq_pkg::*;

`ifdef TDC_SEQ_SETTLE_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hit;
  logic [RAW_W-1:0]  toa_raw, tot_raw, cal_raw;
  logic [CNT_W-1:0]  toa_cntA, toa_cntB, tot_cntA, tot_cntB, cal_cntA, cal_cntB;
  logic              cal_en;
  logic [RAW_W-1:0]  enc_A;
  logic [CNT_W-1:0]  enc_cntA, enc_cntB;
  logic [CODE_W-1:0] enc_code;
  logic              enc_err;
  logic              out_valid, out_ready;
  logic [CODE_W-1:0] out_toa, out_tot, out_cal;
  logic [2:0]        out_err;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  int n_pass  = 0;
  int n_total = 0;

  tdc_enc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .hit(hit),
    .toa_raw(toa_raw), .tot_raw(tot_raw), .cal_raw(cal_raw),
    .toa_cntA(toa_cntA), .toa_cntB(toa_cntB),
    .tot_cntA(tot_cntA), .tot_cntB(tot_cntB),
    .cal_cntA(cal_cntA), .cal_cntB(cal_cntB),
    .cal_en(cal_en),
    .enc_A(enc_A), .enc_cntA(enc_cntA), .enc_cntB(enc_cntB),
    .enc_code(enc_code), .enc_err(enc_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_toa(out_toa), .out_tot(out_tot), .out_cal(out_cal),
    .out_err(out_err), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in encoder: {err, code} = {raw MSB, raw[9:0] ^ {cntA, cntB, 4'b0}}
  function automatic logic [CODE_W:0] fenc(input logic [RAW_W-1:0] a,
                                           input logic [CNT_W-1:0] ca,
                                           input logic [CNT_W-1:0] cb);
    logic [CODE_W-1:0] mask;
    mask = {ca, cb, 4'b0000};
    return {a[RAW_W-1], a[CODE_W-1:0] ^ mask};
  endfunction

  assign {enc_err, enc_code} = fenc(enc_A, enc_cntA, enc_cntB);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: one conversion = list of captures, each lasting S cycles, then a held result.
  bit                m_active = 1'b0;
  int                m_t = 0, m_len = 0, m_drop = 0;
  logic [RAW_W-1:0]  m_raw [3];
  logic [CNT_W-1:0]  m_ca  [3];
  logic [CNT_W-1:0]  m_cb  [3];
  logic [CODE_W-1:0] m_res [3];
  logic [2:0]        m_err = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_t = 0;
        m_len = 0;
        m_drop = 0;
        m_err = '0;
        for (int i = 0; i < 3; i++) m_res[i] = '0;
      end else if (m_active) begin
        if (hit && m_drop < 255) m_drop++;
        if (m_t >= m_len) begin
          if (out_ready) m_active = 1'b0;
        end else begin
          if (m_t % S == S - 1) begin
            logic [CODE_W:0] r;
            int k;
            k = m_t / S;
            r = fenc(m_raw[k], m_ca[k], m_cb[k]);
            m_res[k] = r[CODE_W-1:0];
            m_err[k] = r[CODE_W];
          end
          m_t++;
        end
      end else if (hit) begin
        m_raw[0] = toa_raw;  m_ca[0] = toa_cntA;  m_cb[0] = toa_cntB;
        m_raw[1] = tot_raw;  m_ca[1] = tot_cntA;  m_cb[1] = tot_cntB;
        m_raw[2] = cal_raw;  m_ca[2] = cal_cntA;  m_cb[2] = cal_cntB;
        for (int i = 0; i < 3; i++) m_res[i] = '0;
        m_err    = '0;
        m_len    = (cal_en ? 3 : 2) * S;
        m_t      = 0;
        m_active = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_encA", enc_A, 0);
        chk("rst_enc_cnt", {enc_cntA, enc_cntB}, 0);
        chk("rst_out", {out_toa, out_tot, out_cal, out_err}, 0);
        chk("rst_drop", drop_cnt, 0);
      end else begin
        chk("busy", busy, m_active);
        chk("valid", out_valid, m_active && (m_t >= m_len));
        chk("drop", drop_cnt, m_drop);
        if (!m_active) begin
          chk("idle_encA", enc_A, 0);
          chk("idle_enc_cnt", {enc_cntA, enc_cntB}, 0);
        end else if (m_t < m_len) begin
          chk("encA", enc_A, m_raw[m_t / S]);
          chk("enc_cntA", enc_cntA, m_ca[m_t / S]);
          chk("enc_cntB", enc_cntB, m_cb[m_t / S]);
        end
        if (m_active && m_t >= m_len) begin
          chk("out_toa", out_toa, m_res[0]);
          chk("out_tot", out_tot, m_res[1]);
          chk("out_cal", out_cal, m_res[2]);
          chk("out_err", out_err, m_err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    logic [63:0] t;
    t = {$urandom, $urandom}; toa_raw = t[RAW_W-1:0];
    t = {$urandom, $urandom}; tot_raw = t[RAW_W-1:0];
    t = {$urandom, $urandom}; cal_raw = t[RAW_W-1:0];
    toa_cntA = CNT_W'($urandom_range(0, 7));
    toa_cntB = CNT_W'($urandom_range(0, 7));
    tot_cntA = CNT_W'($urandom_range(0, 7));
    tot_cntB = CNT_W'($urandom_range(0, 7));
    cal_cntA = CNT_W'($urandom_range(0, 7));
    cal_cntB = CNT_W'($urandom_range(0, 7));
    cal_en   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; hit = 1'b0; out_ready = 1'b1; cal_en = 1'b0;
    toa_raw = '0; tot_raw = '0; cal_raw = '0;
    toa_cntA = '0; toa_cntB = '0; tot_cntA = '0; tot_cntB = '0; cal_cntA = '0; cal_cntB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_encA", enc_A, 0);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("lit_idle_busy", busy, 0);
    chk("lit_idle_encA", enc_A, 0);

    // cal_en=1 conversion with hand-picked encoder results
    toa_raw = 63'h123; tot_raw = 63'h045; cal_raw = 63'h4000_0000_0000_03FF;
    cal_en = 1'b1; out_ready = 1'b1; hit = 1'b1;
    tick();
    hit = 1'b0;
    rand_inputs();
    wait_valid(lat);
    chk("lit_lat_cal1", lat, 3 * S);
    chk("lit_toa", out_toa, 10'h123);
    chk("lit_tot", out_tot, 10'h045);
    chk("lit_cal", out_cal, 10'h3FF);
    chk("lit_err", out_err, 3'b100);
    @(posedge clk);
    @(negedge clk);
    chk("lit_idle_after_hs", busy, 0);

    // cal_en=0 conversion: CAL is skipped and reads zero
    @(posedge clk); #1;
    toa_raw = 63'h2AA; toa_cntA = 3'd5; toa_cntB = 3'd2;
    tot_raw = 63'h155; tot_cntA = 3'd0; tot_cntB = 3'd0;
    cal_raw = 63'h4000_0000_0000_03FF;
    cal_en = 1'b0; hit = 1'b1;
    tick();
    hit = 1'b0;
    rand_inputs();
    wait_valid(lat);
    chk("lit_lat_cal0", lat, 2 * S);
    chk("lit_toa_cnt", out_toa, 10'h00A);
    chk("lit_tot_cal0", out_tot, 10'h155);
    chk("lit_cal_skip", out_cal, 10'h000);
    chk("lit_err_cal0", out_err, 3'b000);

    // backpressure with a hit on every cycle, then saturation
    @(posedge clk); #1;
    rand_inputs();
    cal_en = 1'b1; out_ready = 1'b0; hit = 1'b1;
    tick();
    hit = 1'b0;
    wait_valid(lat);
    chk("lit_lat_bp", lat, 3 * S);
    @(posedge clk); #1;
    hit = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("lit_drop10", drop_cnt, 10);
    repeat (290) tick();
    @(negedge clk);
    chk("lit_drop_sat", drop_cnt, 255);
    @(posedge clk); #1;
    hit = 1'b0; out_ready = 1'b1;
    tick();

    // reset while ENC_TOT is active
    rand_inputs();
    cal_en = 1'b1; hit = 1'b1;
    tick();
    hit = 1'b0;
    repeat (S) tick();
    chk("lit_busy_pre_rst", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_abort_busy", busy, 0);
    chk("lit_abort_encA", enc_A, 0);
    chk("lit_abort_out", {out_valid, out_toa, out_tot, out_cal, out_err}, 0);
    chk("lit_abort_drop", drop_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    rand_inputs();
    cal_en = 1'b0; hit = 1'b1;
    tick();
    hit = 1'b0;
    wait_valid(lat);
    chk("lit_lat_after_rst", lat, 2 * S);

    // randomized traffic
    @(posedge clk); #1;
    repeat (600) begin
      rand_inputs();
      hit       = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    hit = 1'b0; out_ready = 1'b1;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
